// File: rtl/ex_hazard_ctrl_if.sv
// ID-stage operand/destination info going into the hazard controller, and the
// stall/bubble/forward-select results coming back out of it.
interface ex_hazard_ctrl_if;
    logic [4:0] in_rs;
    logic [4:0] in_rt;
    logic       in_use_rs;
    logic       in_use_rt;
    logic       in_syscall;
    logic [4:0] in_wreg;
    logic       in_regwrite;
    logic       in_memtoreg;
    logic       in_flush;
    logic       in_lock;
    logic       out_stall;
    logic       out_bubble;
    logic [3:0] out_ALUREDI;
    logic [3:0] out_SYSREDI;

    modport slave (
        input  in_rs, in_rt, in_use_rs, in_use_rt, in_syscall,
        input  in_wreg, in_regwrite, in_memtoreg, in_flush, in_lock,
        output out_stall, out_bubble, out_ALUREDI, out_SYSREDI
    );

    modport master (
        output in_rs, in_rt, in_use_rs, in_use_rt, in_syscall,
        output in_wreg, in_regwrite, in_memtoreg, in_flush, in_lock,
        input  out_stall, out_bubble, out_ALUREDI, out_SYSREDI
    );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// Forwarding-select and load-use hazard controller feeding the EX-stage ALU.
// Define HAZARD_STATS_EN to add saturating stall/flush event counters.
module ex_hazard_ctrl #(
    parameter logic [4:0] REG_V0 = 5'd2,
    parameter logic [4:0] REG_A0 = 5'd4,
    parameter int         CNT_W  = 16
) (
    input  logic              in_CLK,
    input  logic              in_RST,
    ex_hazard_ctrl_if.slave   bus
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0]  out_stall_cnt,
    output logic [CNT_W-1:0]  out_flush_cnt
`endif
);

    typedef enum logic {RUN, STALL} state_t;

    state_t     state_reg, state_next;
    logic [4:0] ex_dst_reg, ex_dst_next;
    logic       ex_wr_reg, ex_wr_next;
    logic       ex_ld_reg, ex_ld_next;
    logic [4:0] mem_dst_reg, mem_dst_next;
    logic       mem_wr_reg, mem_wr_next;
    logic [3:0] alu_sel_reg, alu_sel_next;
    logic [3:0] sys_sel_reg, sys_sel_next;

    // Operand slots: 0 = ALU X (rs), 1 = ALU Y (rt), 2 = syscall $v0, 3 = syscall $a0
    logic [4:0] opnd [4];
    logic [3:0] opnd_use;
    logic [3:0] hit_r;
    logic [3:0] hit_wb;

    logic hazard;
    logic flush_evt;
    logic hazard_evt;
    logic stall_c;
    logic bubble_c;

    assign opnd[0]     = bus.in_rs;
    assign opnd[1]     = bus.in_rt;
    assign opnd[2]     = REG_V0;
    assign opnd[3]     = REG_A0;
    assign opnd_use[0] = bus.in_use_rs;
    assign opnd_use[1] = bus.in_use_rt;
    assign opnd_use[2] = bus.in_syscall;
    assign opnd_use[3] = bus.in_syscall;

    // The EX producer is newer than the MEM producer, so it masks the WB select.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_opnd
            logic nonzero;
            assign nonzero    = (opnd[gi] != 5'd0);
            assign hit_r[gi]  = opnd_use[gi] & ex_wr_reg & (ex_dst_reg == opnd[gi]) & nonzero;
            assign hit_wb[gi] = opnd_use[gi] & mem_wr_reg & (mem_dst_reg == opnd[gi]) & nonzero
                                & ~hit_r[gi];
        end
    endgenerate

    // A load in EX cannot forward in time to any operand that would take the R path.
    assign hazard     = (state_reg == RUN) & ex_ld_reg & (|hit_r);
    assign flush_evt  = ~bus.in_lock & bus.in_flush;
    assign hazard_evt = ~bus.in_lock & ~bus.in_flush & hazard;

    always_comb begin
        state_next   = state_reg;
        ex_dst_next  = ex_dst_reg;
        ex_wr_next   = ex_wr_reg;
        ex_ld_next   = ex_ld_reg;
        mem_dst_next = mem_dst_reg;
        mem_wr_next  = mem_wr_reg;
        alu_sel_next = alu_sel_reg;
        sys_sel_next = sys_sel_reg;
        stall_c      = 1'b0;
        bubble_c     = 1'b0;

        if (bus.in_lock) begin
            stall_c = 1'b1;
        end else if (bus.in_flush) begin
            bubble_c     = 1'b1;
            state_next   = RUN;
            mem_dst_next = ex_dst_reg;
            mem_wr_next  = ex_wr_reg;
            ex_wr_next   = 1'b0;
            ex_ld_next   = 1'b0;
            alu_sel_next = 4'b0000;
            sys_sel_next = 4'b0000;
        end else if (hazard) begin
            stall_c      = 1'b1;
            bubble_c     = 1'b1;
            state_next   = STALL;
            mem_dst_next = ex_dst_reg;
            mem_wr_next  = ex_wr_reg;
            ex_dst_next  = 5'd0;
            ex_wr_next   = 1'b0;
            ex_ld_next   = 1'b0;
            alu_sel_next = 4'b0000;
            sys_sel_next = 4'b0000;
        end else begin
            state_next   = RUN;
            mem_dst_next = ex_dst_reg;
            mem_wr_next  = ex_wr_reg;
            ex_dst_next  = bus.in_wreg;
            ex_wr_next   = bus.in_regwrite;
            ex_ld_next   = bus.in_memtoreg;
            alu_sel_next = {hit_wb[1], hit_wb[0], hit_r[1], hit_r[0]};
            sys_sel_next = {hit_wb[3], hit_wb[2], hit_r[3], hit_r[2]};
        end
    end

    always_ff @(posedge in_CLK) begin
        if (in_RST) begin
            state_reg   <= RUN;
            ex_dst_reg  <= 5'd0;
            ex_wr_reg   <= 1'b0;
            ex_ld_reg   <= 1'b0;
            mem_dst_reg <= 5'd0;
            mem_wr_reg  <= 1'b0;
            alu_sel_reg <= 4'b0000;
            sys_sel_reg <= 4'b0000;
        end else begin
            state_reg   <= state_next;
            ex_dst_reg  <= ex_dst_next;
            ex_wr_reg   <= ex_wr_next;
            ex_ld_reg   <= ex_ld_next;
            mem_dst_reg <= mem_dst_next;
            mem_wr_reg  <= mem_wr_next;
            alu_sel_reg <= alu_sel_next;
            sys_sel_reg <= sys_sel_next;
        end
    end

    assign bus.out_stall   = stall_c;
    assign bus.out_bubble  = bubble_c;
    assign bus.out_ALUREDI = alu_sel_reg;
    assign bus.out_SYSREDI = sys_sel_reg;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt_reg;
    logic [CNT_W-1:0] flush_cnt_reg;

    // Events are already gated by in_lock, so the counters hold while frozen.
    always_ff @(posedge in_CLK) begin
        if (in_RST) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (hazard_evt && (stall_cnt_reg != {CNT_W{1'b1}}))
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            if (flush_evt && (flush_cnt_reg != {CNT_W{1'b1}}))
                flush_cnt_reg <= flush_cnt_reg + 1'b1;
        end
    end

    assign out_stall_cnt = stall_cnt_reg;
    assign out_flush_cnt = flush_cnt_reg;
`else
    logic unused_evt;
    assign unused_evt = flush_evt ^ hazard_evt;
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Scoreboarded bench for ex_hazard_ctrl: expected selects are queued as each ID
// instruction is driven and compared one edge later when it sits in EX.
module tb_ex_hazard_ctrl;

    logic clk;
    logic rst;

    ex_hazard_ctrl_if bus();

`ifdef HAZARD_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    ex_hazard_ctrl dut (
        .in_CLK (clk),
        .in_RST (rst),
        .bus    (bus)
`ifdef HAZARD_STATS_EN
        ,
        .out_stall_cnt (stall_cnt),
        .out_flush_cnt (flush_cnt)
`endif
    );

    typedef struct {
        logic [3:0] alu;
        logic [3:0] sys;
        int         step_id;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit (got running, required finished)");
        $fatal(1, "watchdog");
    end

    // Scoreboard: one queued entry is consumed per edge while tests are stepping.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (bus.out_ALUREDI !== e.alu || bus.out_SYSREDI !== e.sys) begin
                errors++;
                $display("FAIL sel step %0d: got ALUREDI=%b SYSREDI=%b, required ALUREDI=%b SYSREDI=%b",
                         e.step_id, bus.out_ALUREDI, bus.out_SYSREDI, e.alu, e.sys);
            end
        end
    end

    // Drives one ID-stage instruction for one cycle (called at a negedge), samples
    // the combinational stall/bubble and queues the selects expected after the edge.
    task automatic step(input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic sys,
                        input logic [4:0] wreg, input logic rw, input logic ld,
                        input logic flush, input logic lock,
                        input logic [3:0] ealu, input logic [3:0] esys,
                        output logic st, output logic bb);
        exp_t e;
        bus.in_rs       = rs;
        bus.in_rt       = rt;
        bus.in_use_rs   = urs;
        bus.in_use_rt   = urt;
        bus.in_syscall  = sys;
        bus.in_wreg     = wreg;
        bus.in_regwrite = rw;
        bus.in_memtoreg = ld;
        bus.in_flush    = flush;
        bus.in_lock     = lock;
        #1;
        st = bus.out_stall;
        bb = bus.out_bubble;
        step_no++;
        e.alu = ealu;
        e.sys = esys;
        e.step_id = step_no;
        sb.push_back(e);
        @(negedge clk);
        $display("step %0d: rs=%0d rt=%0d wreg=%0d rw=%b ld=%b sys=%b flush=%b lock=%b stall=%b bubble=%b",
                 step_no, rs, rt, wreg, rw, ld, sys, flush, lock, st, bb);
    endtask

    task automatic nop_inputs();
        bus.in_rs = 5'd0; bus.in_rt = 5'd0; bus.in_use_rs = 1'b0; bus.in_use_rt = 1'b0;
        bus.in_syscall = 1'b0; bus.in_wreg = 5'd0; bus.in_regwrite = 1'b0;
        bus.in_memtoreg = 1'b0; bus.in_flush = 1'b0; bus.in_lock = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        nop_inputs();
        repeat (2) @(negedge clk);
        checks++;
        if (bus.out_ALUREDI !== 4'b0000 || bus.out_SYSREDI !== 4'b0000) begin
            errors++;
            $display("FAIL reset_sel: got %b/%b, required 0000/0000", bus.out_ALUREDI, bus.out_SYSREDI);
        end
        checks++;
        if (bus.out_stall !== 1'b0 || bus.out_bubble !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got stall=%b bubble=%b, required 0/0", bus.out_stall, bus.out_bubble);
        end
`ifdef HAZARD_STATS_EN
        checks++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_cnt: got %0d/%0d, required 0/0", stall_cnt, flush_cnt);
        end
`endif
        rst = 1'b0;
        $display("reset released");
    endtask

    task automatic test_forward_ex();
        logic st, bb;
        step(5'd0, 5'd0, 1, 0, 0, 5'd8, 1, 0, 0, 0, 4'b0000, 4'b0000, st, bb); // addi $8
        step(5'd8, 5'd8, 1, 1, 0, 5'd9, 1, 0, 0, 0, 4'b0011, 4'b0000, st, bb); // add $9,$8,$8
        checks++;
        if (st !== 1'b0 || bb !== 1'b0) begin
            errors++;
            $display("FAIL fwd_ex_nostall: got stall=%b bubble=%b, required 0/0", st, bb);
        end
        step(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 4'b0000, 4'b0000, st, bb);
    endtask

    task automatic test_forward_mem();
        logic st, bb;
        step(5'd0, 5'd0, 1, 0, 0, 5'd8,  1, 0, 0, 0, 4'b0000, 4'b0000, st, bb); // addi $8
        step(5'd0, 5'd0, 1, 0, 0, 5'd10, 1, 0, 0, 0, 4'b0000, 4'b0000, st, bb); // addi $10
        step(5'd8, 5'd8, 1, 1, 0, 5'd9,  1, 0, 0, 0, 4'b1100, 4'b0000, st, bb); // add $9,$8,$8
        step(5'd0, 5'd0, 0, 0, 0, 5'd0,  0, 0, 0, 0, 4'b0000, 4'b0000, st, bb);
    endtask

    task automatic test_newest_wins();
        logic st, bb;
        step(5'd0, 5'd0, 1, 0, 0, 5'd8, 1, 0, 0, 0, 4'b0000, 4'b0000, st, bb); // addi $8
        step(5'd8, 5'd0, 1, 0, 0, 5'd8, 1, 0, 0, 0, 4'b0001, 4'b0000, st, bb); // addi $8,$8
        step(5'd8, 5'd8, 1, 1, 0, 5'd9, 1, 0, 0, 0, 4'b0011, 4'b0000, st, bb); // add $9,$8,$8
        step(5'd0, 5'd0, 1, 0, 0, 5'd0, 1, 0, 0, 0, 4'b0000, 4'b0000, st, bb); // addi $0
        step(5'd0, 5'd0, 1, 1, 0, 5'd9, 1, 0, 0, 0, 4'b0000, 4'b0000, st, bb); // add $9,$0,$0
        step(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 4'b0000, 4'b0000, st, bb);
    endtask

    task automatic test_load_use();
        logic st, bb;
        step(5'd0, 5'd0, 1, 0, 0, 5'd8, 1, 1, 0, 0, 4'b0000, 4'b0000, st, bb); // lw $8
        checks++;
        if (st !== 1'b0) begin
            errors++;
            $display("FAIL lu_load_nostall: got stall=%b, required 0", st);
        end
        step(5'd8, 5'd0, 1, 1, 0, 5'd9, 1, 0, 0, 0, 4'b0000, 4'b0000, st, bb); // sub $9,$8,$0
        checks++;
        if (st !== 1'b1 || bb !== 1'b1) begin
            errors++;
            $display("FAIL lu_x_stall: got stall=%b bubble=%b, required 1/1", st, bb);
        end
        step(5'd8, 5'd0, 1, 1, 0, 5'd9, 1, 0, 0, 0, 4'b0100, 4'b0000, st, bb); // reissued
        checks++;
        if (st !== 1'b0 || bb !== 1'b0) begin
            errors++;
            $display("FAIL lu_x_one_cycle: got stall=%b bubble=%b, required 0/0", st, bb);
        end
        step(5'd0, 5'd0, 1, 0, 0, 5'd8, 1, 1, 0, 0, 4'b0000, 4'b0000, st, bb); // lw $8
        step(5'd0, 5'd8, 1, 1, 0, 5'd9, 1, 0, 0, 0, 4'b0000, 4'b0000, st, bb); // add $9,$0,$8
        checks++;
        if (st !== 1'b1 || bb !== 1'b1) begin
            errors++;
            $display("FAIL lu_y_stall: got stall=%b bubble=%b, required 1/1", st, bb);
        end
        step(5'd0, 5'd8, 1, 1, 0, 5'd9, 1, 0, 0, 0, 4'b1000, 4'b0000, st, bb);
        step(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 4'b0000, 4'b0000, st, bb);
`ifdef HAZARD_STATS_EN
        checks++;
        if (stall_cnt !== 16'd2) begin
            errors++;
            $display("FAIL lu_stall_cnt: got %0d, required 2", stall_cnt);
        end
`endif
    endtask

    task automatic test_syscall();
        logic st, bb;
        step(5'd0, 5'd0, 1, 0, 0, 5'd2, 1, 1, 0, 0, 4'b0000, 4'b0000, st, bb); // lw $2
        step(5'd0, 5'd0, 0, 0, 1, 5'd0, 0, 0, 0, 0, 4'b0000, 4'b0000, st, bb); // syscall
        checks++;
        if (st !== 1'b1 || bb !== 1'b1) begin
            errors++;
            $display("FAIL sys_stall: got stall=%b bubble=%b, required 1/1", st, bb);
        end
        step(5'd0, 5'd0, 0, 0, 1, 5'd0, 0, 0, 0, 0, 4'b0000, 4'b0100, st, bb); // reissued
        step(5'd0, 5'd0, 1, 0, 0, 5'd4, 1, 0, 0, 0, 4'b0000, 4'b0000, st, bb); // addi $4
        step(5'd0, 5'd0, 0, 0, 1, 5'd0, 0, 0, 0, 0, 4'b0000, 4'b0010, st, bb); // syscall
        checks++;
        if (st !== 1'b0) begin
            errors++;
            $display("FAIL sys_alu_nostall: got stall=%b, required 0", st);
        end
        step(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 4'b0000, 4'b0000, st, bb);
    endtask

    task automatic test_back_to_back();
        logic st, bb;
        step(5'd0, 5'd0, 1, 0, 0, 5'd8,  1, 1, 0, 0, 4'b0000, 4'b0000, st, bb); // lw $8
        step(5'd8, 5'd0, 1, 0, 0, 5'd9,  1, 1, 0, 0, 4'b0000, 4'b0000, st, bb); // lw $9,0($8)
        step(5'd8, 5'd0, 1, 0, 0, 5'd9,  1, 1, 0, 0, 4'b0100, 4'b0000, st, bb);
        step(5'd9, 5'd9, 1, 1, 0, 5'd10, 1, 0, 0, 0, 4'b0000, 4'b0000, st, bb); // add $10,$9,$9
        checks++;
        if (st !== 1'b1 || bb !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second_stall: got stall=%b bubble=%b, required 1/1", st, bb);
        end
        step(5'd9, 5'd9, 1, 1, 0, 5'd10, 1, 0, 0, 0, 4'b1100, 4'b0000, st, bb);
        step(5'd0, 5'd0, 0, 0, 0, 5'd0,  0, 0, 0, 0, 4'b0000, 4'b0000, st, bb);
`ifdef HAZARD_STATS_EN
        checks++;
        if (stall_cnt !== 16'd5) begin
            errors++;
            $display("FAIL b2b_stall_cnt: got %0d, required 5", stall_cnt);
        end
`endif
    endtask

    task automatic test_flush_lock();
        logic st, bb;
        step(5'd0, 5'd0, 1, 0, 0, 5'd8, 1, 1, 0, 0, 4'b0000, 4'b0000, st, bb); // lw $8
        step(5'd8, 5'd0, 1, 1, 0, 5'd9, 1, 0, 1, 0, 4'b0000, 4'b0000, st, bb); // sub + flush
        checks++;
        if (st !== 1'b0 || bb !== 1'b1) begin
            errors++;
            $display("FAIL flush_over_hazard: got stall=%b bubble=%b, required 0/1", st, bb);
        end
        step(5'd8, 5'd0, 1, 1, 0, 5'd9, 1, 0, 0, 0, 4'b0100, 4'b0000, st, bb); // add $9,$8,$0
        for (int i = 0; i < 3; i++) begin
            step(5'd9, 5'd0, 1, 0, 0, 5'd8, 1, 0, (i == 1), 1, 4'b0100, 4'b0000, st, bb);
            checks++;
            if (st !== 1'b1 || bb !== 1'b0) begin
                errors++;
                $display("FAIL lock_%0d: got stall=%b bubble=%b, required 1/0", i, st, bb);
            end
        end
        step(5'd9, 5'd0, 1, 0, 0, 5'd8,  1, 0, 0, 0, 4'b0001, 4'b0000, st, bb); // addi $8,$9
        step(5'd8, 5'd8, 1, 1, 0, 5'd10, 1, 0, 0, 0, 4'b0011, 4'b0000, st, bb); // add $10,$8,$8
        step(5'd0, 5'd0, 0, 0, 0, 5'd0,  0, 0, 0, 0, 4'b0000, 4'b0000, st, bb);
`ifdef HAZARD_STATS_EN
        checks++;
        if (flush_cnt !== 16'd1 || stall_cnt !== 16'd5) begin
            errors++;
            $display("FAIL flush_lock_cnt: got flush=%0d stall=%0d, required 1/5", flush_cnt, stall_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid_stall();
        logic st, bb;
        step(5'd0, 5'd0, 1, 0, 0, 5'd8, 1, 1, 0, 0, 4'b0000, 4'b0000, st, bb); // lw $8
        step(5'd8, 5'd0, 1, 1, 0, 5'd9, 1, 0, 0, 0, 4'b0000, 4'b0000, st, bb); // stall edge
        rst = 1'b1;
        nop_inputs();
        @(negedge clk);
        rst = 1'b0;
        $display("reset pulsed during STALL");
        checks++;
        if (bus.out_ALUREDI !== 4'b0000 || bus.out_SYSREDI !== 4'b0000) begin
            errors++;
            $display("FAIL midstall_sel: got %b/%b, required 0000/0000", bus.out_ALUREDI, bus.out_SYSREDI);
        end
        step(5'd8, 5'd0, 1, 1, 0, 5'd9, 1, 0, 0, 0, 4'b0000, 4'b0000, st, bb); // reissued
        checks++;
        if (st !== 1'b0 || bb !== 1'b0) begin
            errors++;
            $display("FAIL midstall_reissue: got stall=%b bubble=%b, required 0/0", st, bb);
        end
        step(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 4'b0000, 4'b0000, st, bb);
`ifdef HAZARD_STATS_EN
        checks++;
        if (stall_cnt !== 16'd0) begin
            errors++;
            $display("FAIL midstall_cnt: got %0d, required 0", stall_cnt);
        end
`endif
    endtask

    initial begin
        rst = 1'b1;
        nop_inputs();
        @(negedge clk);
        test_reset();
        test_forward_ex();
        test_forward_mem();
        test_newest_wins();
        test_load_use();
        test_syscall();
        test_back_to_back();
        test_flush_lock();
        test_reset_mid_stall();
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
